// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared FSM encoding and default sizing for the MEM/WB stage
package mem_wb_stage_pkg;

    localparam int DEFAULT_MEM_DEPTH   = 32;
    localparam int DEFAULT_MEM_LATENCY = 3;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_wb_stage_data_memory.sv
// rtl/mem_wb_stage_data_memory.sv - word-addressed data memory, sync write / async read
//
// Ports:
//   clk    - write clock
//   we     - write enable, sampled on rising clk
//   addr   - word address
//   wdata  - store data
//   rdata  - combinational read of memory[addr]
//
// Contents are deliberately not reset.
module data_memory #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage with multi-cycle data memory access and MEM/WB pipeline register
//
// Ports:
//   clk, reset              - clock, asynchronous active-low reset
//   MEM_Flush               - kill the operation currently in the stage
//   RegWrite_in/MemtoReg_in - WB controls from EX/MEM
//   MemRead_in/MemWrite_in  - MEM controls from EX/MEM
//   ALU_result_in           - ALU value / byte address
//   reg_read_data_2_in      - store data
//   EX_MEM_RegisterRd_in    - destination register
//   RegWrite_out..MEM_WB_RegisterRd_out - registered MEM/WB outputs
//   Mem_Stall               - combinational hold request to upstream stages
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int MEM_DEPTH   = DEFAULT_MEM_DEPTH,
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_Flush,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] reg_read_data_2_in,
    input  logic [4:0]  EX_MEM_RegisterRd_in,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [31:0] mem_read_data_out,
    output logic [31:0] ALU_result_out,
    output logic [4:0]  MEM_WB_RegisterRd_out,
    output logic        Mem_Stall
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);
    // Counter only has to hold MEM_LATENCY-2.
    localparam int CNT_W  = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;

    state_t             state, stateNext;
    logic [CNT_W-1:0]   cnt, cntNext;
    logic               memOp;
    logic               capture;
    logic               memWe;
    logic               isLoad;
    logic [ADDR_W-1:0]  wordAddr;
    logic [31:0]        memRdata;

    assign memOp    = (MemRead_in | MemWrite_in) & ~MEM_Flush;
    // Write wins when both controls are set, so only a pure read returns data.
    assign isLoad   = MemRead_in & ~MemWrite_in;
    assign wordAddr = ALU_result_in[ADDR_W+1:2];
    // capture already excludes flush; gating with reset keeps an aborted store out of memory.
    assign memWe    = capture & MemWrite_in & reset;

    data_memory #(
        .DEPTH  (MEM_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_data_memory (
        .clk   (clk),
        .we    (memWe),
        .addr  (wordAddr),
        .wdata (reg_read_data_2_in),
        .rdata (memRdata)
    );

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        capture   = 1'b0;
        Mem_Stall = 1'b0;
        if (MEM_Flush) begin
            stateNext = IDLE;
            cntNext   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memOp && (MEM_LATENCY > 1)) begin
                        Mem_Stall = 1'b1;
                        stateNext = WAIT;
                        cntNext   = CNT_W'(MEM_LATENCY - 2);
                    end else begin
                        capture = 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        Mem_Stall = 1'b1;
                        cntNext   = cnt - CNT_W'(1);
                    end else begin
                        capture   = 1'b1;
                        stateNext = IDLE;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
        // Upstream must never be held while the stage itself is in reset.
        if (!reset) begin
            Mem_Stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Anything that is not a completing operation leaves a bubble in MEM/WB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWrite_out          <= 1'b0;
            MemtoReg_out          <= 1'b0;
            mem_read_data_out     <= '0;
            ALU_result_out        <= '0;
            MEM_WB_RegisterRd_out <= '0;
        end else if (capture) begin
            RegWrite_out          <= RegWrite_in;
            MemtoReg_out          <= MemtoReg_in;
            mem_read_data_out     <= isLoad ? memRdata : 32'h0;
            ALU_result_out        <= ALU_result_in;
            MEM_WB_RegisterRd_out <= EX_MEM_RegisterRd_in;
        end else begin
            RegWrite_out          <= 1'b0;
            MemtoReg_out          <= 1'b0;
            mem_read_data_out     <= '0;
            ALU_result_out        <= '0;
            MEM_WB_RegisterRd_out <= '0;
        end
    end

endmodule
